// File: rtl/cpu_sequencer.sv
// cpu_sequencer: command sequencer between a fetcher, a decoder and an executor.
// It walks IDLE -> FETCH -> DECODE -> EXEC -> WAIT and then back to FETCH or
// IDLE. The PC and the retired-command count advance only when a command
// completes. HALT and ERROR stay set until reset.
//
// Optional feature: define SEQ_WATCHDOG_EN to add the WAIT watchdog. With it,
// WAIT moves to ERROR after WDOG_LIMIT cycles without READY_FL_.
//
// Ports:
//   CLK_               clock; all state changes on the rising edge
//   RST_               synchronous active-high reset
//   RUN_               run enable
//   FETCH_REQ_         fetch request; high only in FETCH
//   FETCH_ADDR_        fetch address; always equal to PC_
//   FETCH_VALID_       CMD_SIZE_/CMD_FLGS_ valid; sampled only in FETCH
//   CMD_SIZE_          command size in 32-bit words (0 is illegal)
//   CMD_FLGS_          decoder flags; bit 5 = HALT
//   EXEC_FL_           one-cycle executor start pulse; high only in EXEC
//   READY_FL_          executor done; sampled only in WAIT
//   JMP_FL_            completed command is a taken jump; sampled with READY_FL_
//   NEW_EXEC_ADDR_OFF_ signed byte offset of the jump target, relative to PC_
//   PC_                program counter
//   STATE_             FSM state encoding
//   RETIRED_CNT_       count of completed commands
//   HALT_FL_           high while in HALT
//   ERR_FL_            high while in ERROR
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned WDOG_LIMIT = 16
) (
    input  logic        CLK_,
    input  logic        RST_,
    input  logic        RUN_,
    output logic        FETCH_REQ_,
    output logic [31:0] FETCH_ADDR_,
    input  logic        FETCH_VALID_,
    input  logic [1:0]  CMD_SIZE_,
    input  logic [5:0]  CMD_FLGS_,
    output logic        EXEC_FL_,
    input  logic        READY_FL_,
    input  logic        JMP_FL_,
    input  logic [31:0] NEW_EXEC_ADDR_OFF_,
    output logic [31:0] PC_,
    output logic [2:0]  STATE_,
    output logic [31:0] RETIRED_CNT_,
    output logic        HALT_FL_,
    output logic        ERR_FL_
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic        halt_q, err_q;
`ifdef SEQ_WATCHDOG_EN
    logic [31:0] wdog_q, wdog_d;
`endif

    // State register
    always_ff @(posedge CLK_) begin
        if (RST_) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            size_q  <= '0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            // Both flags decode the next state, so they change in the same cycle as STATE_.
            halt_q  <= (state_d == S_HALT);
            err_q   <= (state_d == S_ERROR);
`ifdef SEQ_WATCHDOG_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
`ifdef SEQ_WATCHDOG_EN
        wdog_d  = wdog_q;
`endif
        unique case (state_q)
            S_IDLE:   if (RUN_) state_d = S_FETCH;
            S_FETCH:  if (FETCH_VALID_) state_d = S_DECODE;
            S_DECODE: begin
                size_d = CMD_SIZE_;
                if (CMD_SIZE_ == 2'd0)  state_d = S_ERROR;
                else if (CMD_FLGS_[5])  state_d = S_HALT;
                else                    state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WAIT;
`ifdef SEQ_WATCHDOG_EN
                wdog_d  = '0;
`endif
            end
            S_WAIT: begin
                if (READY_FL_) begin
                    // Jump offsets and size increments both wrap modulo 2^32.
                    pc_d    = pc_q + (JMP_FL_ ? NEW_EXEC_ADDR_OFF_ : {28'd0, size_q, 2'b00});
                    cnt_d   = cnt_q + 32'd1;
                    state_d = RUN_ ? S_FETCH : S_IDLE;
                end
`ifdef SEQ_WATCHDOG_EN
                else begin
                    // The count reaches the limit on this cycle, so the next edge
                    // enters ERROR. READY_FL_ in the same cycle still completes.
                    wdog_d = wdog_q + 32'd1;
                    if (wdog_q == 32'(WDOG_LIMIT - 1)) state_d = S_ERROR;
                end
`endif
            end
            S_HALT:   state_d = S_HALT;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        FETCH_REQ_   = (state_q == S_FETCH);
        EXEC_FL_     = (state_q == S_EXEC);
        FETCH_ADDR_  = pc_q;
        PC_          = pc_q;
        STATE_       = state_q;
        RETIRED_CNT_ = cnt_q;
        HALT_FL_     = halt_q;
        ERR_FL_      = err_q;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning program counter value loaded on reset.
REQ-002 SHALL have parameter WDOG_LIMIT, default 16, meaning the maximum number of WAIT cycles allowed when the watchdog is compiled in.
REQ-003 SHALL have port CLK_, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST_, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port RUN_, input, 1 bit: run enable.
REQ-006 SHALL have port FETCH_REQ_, output, 1 bit: request to the fetcher for the command at FETCH_ADDR_.
REQ-007 SHALL have port FETCH_ADDR_, output, 32 bits: address of the command to fetch; always equals PC_.
REQ-008 SHALL have port FETCH_VALID_, input, 1 bit: CMD_SIZE_ and CMD_FLGS_ are valid for the fetched command.
REQ-009 SHALL have port CMD_SIZE_, input, 2 bits: command size in 32-bit words, from the decoder.
REQ-010 SHALL have port CMD_FLGS_, input, 6 bits: decoder flags; bit 5 means HALT.
REQ-011 SHALL have port EXEC_FL_, output, 1 bit: one-cycle start pulse to the executor.
REQ-012 SHALL have port READY_FL_, input, 1 bit: the executor has finished the current command.
REQ-013 SHALL have port JMP_FL_, input, 1 bit: the finished command is a taken jump; sampled only with READY_FL_.
REQ-014 SHALL have port NEW_EXEC_ADDR_OFF_, input, 32 bits: signed byte offset of the jump target, relative to the current PC.
REQ-015 SHALL have port PC_, output, 32 bits: current program counter.
REQ-016 SHALL have port STATE_, output, 3 bits: current FSM state encoding.
REQ-017 SHALL have port RETIRED_CNT_, output, 32 bits: count of completed commands.
REQ-018 SHALL have port HALT_FL_, output, 1 bit: high while in HALT.
REQ-019 SHALL have port ERR_FL_, output, 1 bit: high while in ERROR.

Function
REQ-020 SHALL implement the FSM encodings IDLE=0, FETCH=1, DECODE=2, EXEC=3, WAIT=4, HALT=5, ERROR=6.
REQ-021 In IDLE, the FSM SHALL move to FETCH on the cycle after RUN_=1; otherwise it stays in IDLE.
REQ-022 In FETCH, FETCH_REQ_ SHALL be 1 (and 0 in every other state); FETCH_VALID_=1 -> DECODE, else stay in FETCH.
REQ-023 In DECODE (exactly 1 cycle), CMD_SIZE_ SHALL be latched into an internal size register; the next state is chosen by the first matching rule:
  - CMD_SIZE_=0 -> ERROR;
  - CMD_FLGS_[5]=1 -> HALT;
  - else -> EXEC.
REQ-024 In EXEC (exactly 1 cycle), EXEC_FL_ SHALL be 1, then -> WAIT; EXEC_FL_ is 0 in every other state.
REQ-025 In WAIT with READY_FL_=1:
  - PC_ SHALL update to PC_+NEW_EXEC_ADDR_OFF_ if JMP_FL_=1, else to PC_+4*size;
  - the addition is modulo 2^32 (wraps, no flag);
  - RETIRED_CNT_ increments by 1, wrapping at 2^32;
  - next state is FETCH if RUN_=1, else IDLE.
REQ-026 In WAIT with READY_FL_=0, the FSM SHALL stay in WAIT with PC_ unchanged.
REQ-027 READY_FL_ and JMP_FL_ SHALL be ignored outside WAIT; FETCH_VALID_ SHALL be ignored outside FETCH.
REQ-028 RUN_=0 SHALL NOT abort an in-flight command; it is honoured only in IDLE and at WAIT completion.
REQ-029 HALT and ERROR SHALL be sticky until reset; PC_ and RETIRED_CNT_ hold their values.
REQ-030 PC_ SHALL change only on WAIT completion or reset.
REQ-031 A halting command SHALL NOT be counted in RETIRED_CNT_ or advance PC_.
REQ-032 HALT_FL_ and ERR_FL_ SHALL be registered decodes of the state (valid in the same cycle as STATE_).

Reset
REQ-033 RST_=1 at a clock edge SHALL force STATE_=IDLE, PC_=RESET_PC, RETIRED_CNT_=0, FETCH_REQ_=0, EXEC_FL_=0, HALT_FL_=0, ERR_FL_=0, size=0, and the watchdog count to 0.
REQ-034 Reset SHALL take priority over all other inputs in every state, including mid-WAIT; a pending READY_FL_ in the same cycle is discarded.

Configuration
REQ-035 Macro SEQ_WATCHDOG_EN defined: a counter SHALL clear on WAIT entry and increment each WAIT cycle with READY_FL_=0; reaching WDOG_LIMIT -> ERROR on the next edge. READY_FL_ in the same cycle as the limit is reached wins (normal completion).
REQ-036 Macro SEQ_WATCHDOG_EN undefined: no watchdog counter SHALL exist and WAIT lasts indefinitely; ERROR is reachable only via CMD_SIZE_=0.

Verification
REQ-037 Reset with RESET_PC=0x100, then RUN_=1, size 3, no jump, READY_FL_ 2 cycles after EXEC_FL_ -> PC_=0x10C, RETIRED_CNT_=1, second FETCH_REQ_ observed.
REQ-038 Jump with NEW_EXEC_ADDR_OFF_=0xFFFFFFF0 at PC_=0x8 -> PC_=0xFFFFFFF8 (wrap), RETIRED_CNT_ increments.
REQ-039 CMD_FLGS_=6'b100000 at DECODE -> HALT_FL_=1, STATE_=5, PC_ unchanged, no EXEC_FL_ pulse; a later RUN_ toggle has no effect.
REQ-040 CMD_SIZE_=0 at DECODE -> ERR_FL_=1, STATE_=6; RST_ pulse -> STATE_=0, PC_=RESET_PC, RETIRED_CNT_=0.
REQ-041 With SEQ_WATCHDOG_EN and WDOG_LIMIT=4, READY_FL_ held 0 -> ERROR after 4 WAIT cycles; without the macro -> still WAIT after 100 cycles.
REQ-042 RUN_ dropped during WAIT, then READY_FL_=1 -> PC_ advances, STATE_=IDLE, FETCH_REQ_ stays 0.
